dm_cache: RTL and testbench
===========================

# dm_cache

Direct-mapped, write-back, write-allocate data cache between the RISC-V core's data port and the 128-bit `slow_memory`. It is the initiator on the memory handshake: it issues block reads and writes and waits for the one-cycle `mem_ready` pulse. It also answers core word accesses on hits, and stalls the core on misses until the block is resident.

## Interface
- `LINE_NUM`, 8: number of cache lines (power of two).
- `IDX_W`, 3: index width, log2(`LINE_NUM`).
- `TAG_W`, 25: tag width, 28 − `IDX_W`.
- `clk` in 1: single clock; all cache state updates on posedge.
- `proc_reset` in 1: asynchronous, active-high reset.
- `proc_read` in 1: core word read request.
- `proc_write` in 1: core word write request.
- `proc_addr` in 30: word address. [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- `proc_wdata` in 32: write data.
- `proc_stall` out 1: core must hold its request stable while this is high.
- `proc_rdata` out 32: read data, valid when `proc_read`=1 and `proc_stall`=0.
- `mem_read` out 1: block read request (registered).
- `mem_write` out 1: block write request (registered).
- `mem_addr` out 28: block address, word address >> 2 (registered).
- `mem_wdata` out 128: block write data, word 0 in [31:0] (registered).
- `mem_rdata` in 128: block read data, valid while `mem_ready`=1.
- `mem_ready` in 1: single-cycle completion pulse from memory.

## Operation
- Per-line storage: `valid`, `dirty`, tag (`TAG_W`), data (4×32).
- Hit condition: `valid[idx]` and `tag[idx]` == addr tag.
- States: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE, no request: idle, `proc_stall`=0.
- COMPARE, read hit: `proc_rdata` = word[offset] combinationally, `proc_stall`=0.
- COMPARE, write hit: `proc_stall`=0. At posedge, word[offset] ← `proc_wdata` and `dirty`←1.
- COMPARE, miss on a clean or invalid line: `proc_stall`=1. Next state is ALLOCATE; load `mem_read`=1, `mem_write`=0, `mem_addr`=`proc_addr[29:2]`.
- COMPARE, miss on a dirty line: `proc_stall`=1. Next state is WRITEBACK; load `mem_write`=1, `mem_read`=0, `mem_addr`={old tag, idx}, `mem_wdata`=line data.
- WRITEBACK: hold all `mem_*` outputs until `mem_ready`=1. Then: next state ALLOCATE; load `mem_write`=0, `mem_read`=1, `mem_addr`=`proc_addr[29:2]`; set `dirty[idx]`←0.
- ALLOCATE: hold outputs until `mem_ready`=1. Then: line data←`mem_rdata`, tag←addr tag, `valid`←1, `dirty`←0, `mem_read`←0; next state COMPARE.
- Back in COMPARE after a miss, the replayed access hits. A write miss merges `proc_wdata` in that hit cycle.
- `proc_stall` = (request and not hit) in COMPARE; 1 in WRITEBACK and ALLOCATE.
- `proc_read` and `proc_write` both high: treated as a read; no array write.
- No request in COMPARE: `proc_rdata`=0.
- `mem_ready` seen while in COMPARE: ignored.
- Core request changing while stalled is illegal. The cache re-samples `proc_addr` each cycle and does not latch it.
- `proc_reset`=1 at any time, including mid-miss:
  - State goes to COMPARE.
  - All `valid` and `dirty` bits are cleared.
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` go to 0.
  - Data and tag arrays need no reset.

## Timing
- Read hit and write hit: 0 stall cycles. Back-to-back hits are sustained every cycle.
- Memory request rises at the first posedge after the miss is detected. It stays stable through the posedge at which `mem_ready`=1 is sampled.
- The request deasserts, or switches directly from write to read, at that same posedge. It is never held into the memory's post-ready cycle.
- Clean miss: `proc_stall` falls in the cycle after the ALLOCATE `mem_ready` edge.
- Dirty miss: the WRITEBACK handshake completes, then ALLOCATE runs; no idle cycle in between.
- `mem_wdata` and `mem_addr` do not change while a request is asserted.
- Reset values: `proc_stall`=0 (no request), `proc_rdata`=0, all `mem_*` outputs 0.

## Test plan
- Reset, then read 0x0000_0004:
  - `proc_stall`=1.
  - `mem_read`=1 with `mem_addr`=0x000_0001.
  - Memory returns 0x4444…_1111 (four distinct words).
  - `proc_stall` falls one cycle after `mem_ready`; `proc_rdata`=word 0.
- After that fill, read offsets 1, 2, 3 on consecutive cycles: zero stalls, correct words, no memory request.
- Write 0xDEAD_BEEF to 0x0000_0005 (hit).
- Then read 0x0000_0025, same index with a different tag:
  - WRITEBACK issues `mem_write`=1, `mem_addr`=0x000_0001, `mem_wdata[63:32]`=0xDEAD_BEEF.
  - Then `mem_read`=1, `mem_addr`=0x000_0009.
  - Then hit.
- Write miss to a clean line at 0x0000_0042 with 0x1234_5678:
  - Allocate, then merge.
  - A later eviction writeback carries 0x1234_5678 in `mem_wdata[95:64]`.
- Assert `proc_reset` while in ALLOCATE with `mem_read`=1:
  - `mem_read` drops to 0 immediately.
  - A subsequent read of the previously cached address misses.
- Drive `proc_read` and `proc_write` together on a hit: read data returned, line contents unchanged, `dirty` unchanged.

Source files
------------

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the core data
// port and a 128-bit block memory that completes with a one-cycle ready pulse.
module dm_cache #(
  parameter int unsigned LINE_NUM = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned TAG_W    = 25
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t              state;
  logic [LINE_NUM-1:0] valid;
  logic [LINE_NUM-1:0] dirty;
  logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
  logic [BLK_W-1:0]    data_mem [LINE_NUM];

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [BLK_W-1:0] line;
  logic [6:0]       word_base;
  logic             req;
  logic             wr_only;
  logic             hit;

  assign off       = proc_addr[1:0];
  assign idx       = proc_addr[IDX_W+1:2];
  assign tag       = proc_addr[29:IDX_W+2];
  assign line      = data_mem[idx];
  assign word_base = {off, 5'd0};
  assign req       = proc_read | proc_write;
  // A simultaneous read and write is serviced as a read only.
  assign wr_only   = proc_write & ~proc_read;
  assign hit       = valid[idx] && (tag_mem[idx] == tag);

  // Core-facing handshake is combinational so hits complete with no stall.
  always_comb begin
    proc_stall = 1'b1;
    proc_rdata = '0;
    if (state == COMPARE) begin
      proc_stall = req && !hit;
      if (proc_read && hit) begin
        proc_rdata = line[word_base +: WORD_W];
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their contents.
  always_ff @(posedge clk) begin
    if (!proc_reset) begin
      if (state == COMPARE && wr_only && hit) begin
        data_mem[idx][word_base +: WORD_W] <= proc_wdata;
      end else if (state == ALLOCATE && mem_ready) begin
        data_mem[idx] <= mem_rdata;
        tag_mem[idx]  <= tag;
      end
    end
  end

  // Miss handling FSM with registered memory request outputs.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state     <= COMPARE;
      valid     <= '0;
      dirty     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (req && !hit) begin
            if (valid[idx] && dirty[idx]) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
              mem_read  <= 1'b0;
              mem_addr  <= {tag_mem[idx], idx};
              mem_wdata <= line;
            end else begin
              state     <= ALLOCATE;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_addr  <= proc_addr[29:2];
            end
          end else if (wr_only && hit) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state      <= ALLOCATE;
            mem_write  <= 1'b0;
            mem_read   <= 1'b1;
            mem_addr   <= proc_addr[29:2];
            dirty[idx] <= 1'b0;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state      <= COMPARE;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            mem_read   <= 1'b0;
          end
        end
        default: state <= COMPARE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: hit vector table plus directed miss,
// writeback, reset-abort and read/write-collision sequences.
module tb_dm_cache;

  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_chk  = 0;
  int n_fail = 0;

  dm_cache #(.LINE_NUM(8), .IDX_W(3), .TAG_W(25)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read),
    .proc_write(proc_write), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Block memory model: fixed latency, one-cycle ready pulse, transaction log.
  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic [127:0] store [256];
  txn_t         mem_log [$];
  int           lat_cnt = 0;
  int           stab_err = 0;
  logic         held = 1'b0;
  logic         h_rd;
  logic [27:0]  h_addr;
  logic [127:0] h_wdata;
  logic         last_wr;

  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
      held = 1'b0;
      if (last_wr ? mem_write : mem_read) stab_err++;
    end else if (mem_read || mem_write) begin
      if (held && (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_read !== h_rd))
        stab_err++;
      held = 1'b1; h_rd = mem_read; h_addr = mem_addr; h_wdata = mem_wdata;
      lat_cnt++;
      if (lat_cnt == MEM_LAT) begin
        lat_cnt = 0;
        last_wr = mem_write;
        if (mem_write) begin
          store[mem_addr[7:0]] = mem_wdata;
          mem_log.push_back('{1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = store[mem_addr[7:0]];
          mem_log.push_back('{1'b0, mem_addr, 128'd0});
        end
        mem_ready = 1'b1;
      end
    end else begin
      lat_cnt = 0;
      held = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one access and hold it until the stall clears (bounded).
  task automatic access(input logic rd, input logic wr, input logic [29:0] addr,
                        input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
    stalls = 0;
    #1;
    while (proc_stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rdata = proc_rdata;
    if (proc_stall) chk("stall_timeout", 128'(proc_stall), 128'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  int          st;
  logic [31:0] rd_v;
  int          k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"hit_off1",    1'b1, 1'b0, 30'h5, 32'h0,         32'h0001_2222};
    vecs[1] = '{"hit_off2",    1'b1, 1'b0, 30'h6, 32'h0,         32'h0001_3333};
    vecs[2] = '{"hit_off3",    1'b1, 1'b0, 30'h7, 32'h0,         32'h0001_4444};
    vecs[3] = '{"write_hit",   1'b0, 1'b1, 30'h5, 32'hDEAD_BEEF, 32'h0};
    vecs[4] = '{"readback",    1'b1, 1'b0, 30'h5, 32'h0,         32'hDEAD_BEEF};
    vecs[5] = '{"hit_off0",    1'b1, 1'b0, 30'h4, 32'h0,         32'h0001_1111};

    for (int b = 0; b < 256; b++) begin
      logic [15:0] bb;
      bb = 16'(b);
      store[b] = {bb, 16'h4444, bb, 16'h3333, bb, 16'h2222, bb, 16'h1111};
    end

    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 128'(proc_stall), 128'd0);
    chk("rst_rdata", 128'(proc_rdata), 128'd0);
    chk("rst_mem_req", 128'({mem_read, mem_write}), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    proc_reset = 1'b0;

    // Clean miss from reset.
    mem_log.delete();
    access(1'b1, 1'b0, 30'h4, 32'h0, st, rd_v);
    chk("clean_miss_stalls", 128'(st), 128'(1 + MEM_LAT));
    chk("clean_miss_rdata", 128'(rd_v), 128'h0001_1111);
    chk("clean_miss_nreq", 128'(mem_log.size()), 128'd1);
    if (mem_log.size() >= 1) begin
      chk("clean_miss_op", 128'(mem_log[0].wr), 128'd0);
      chk("clean_miss_addr", 128'(mem_log[0].addr), 128'h1);
    end

    // Back-to-back hits, one per cycle, no memory traffic.
    mem_log.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      proc_read = vecs[i].rd; proc_write = vecs[i].wr;
      proc_addr = vecs[i].addr; proc_wdata = vecs[i].wdata;
      #1;
      chk({vecs[i].name, "_stall"}, 128'(proc_stall), 128'd0);
      if (vecs[i].rd) chk({vecs[i].name, "_rdata"}, 128'(proc_rdata), 128'(vecs[i].exp_rdata));
    end
    chk("hits_no_mem", 128'(mem_log.size()), 128'd0);

    // Dirty miss: writeback then allocate.
    mem_log.delete();
    access(1'b1, 1'b0, 30'h25, 32'h0, st, rd_v);
    chk("dirty_miss_stalls", 128'(st), 128'(2 + 2 * MEM_LAT));
    chk("dirty_miss_rdata", 128'(rd_v), 128'h0009_2222);
    chk("dirty_miss_nreq", 128'(mem_log.size()), 128'd2);
    if (mem_log.size() >= 2) begin
      chk("wb_op", 128'(mem_log[0].wr), 128'd1);
      chk("wb_addr", 128'(mem_log[0].addr), 128'h1);
      chk("wb_word1", 128'(mem_log[0].wdata[63:32]), 128'hDEAD_BEEF);
      chk("wb_word0", 128'(mem_log[0].wdata[31:0]), 128'h0001_1111);
      chk("alloc_op", 128'(mem_log[1].wr), 128'd0);
      chk("alloc_addr", 128'(mem_log[1].addr), 128'h9);
    end

    // Evicted line was clean after refill; old block comes back from memory.
    mem_log.delete();
    access(1'b1, 1'b0, 30'h5, 32'h0, st, rd_v);
    chk("refetch_stalls", 128'(st), 128'(1 + MEM_LAT));
    chk("refetch_rdata", 128'(rd_v), 128'hDEAD_BEEF);
    chk("refetch_nreq", 128'(mem_log.size()), 128'd1);

    // Write miss on an invalid line: allocate then merge.
    mem_log.delete();
    access(1'b0, 1'b1, 30'h42, 32'h1234_5678, st, rd_v);
    chk("wmiss_stalls", 128'(st), 128'(1 + MEM_LAT));
    chk("wmiss_nreq", 128'(mem_log.size()), 128'd1);
    if (mem_log.size() >= 1) chk("wmiss_addr", 128'(mem_log[0].addr), 128'h10);
    access(1'b1, 1'b0, 30'h42, 32'h0, st, rd_v);
    chk("wmiss_merge_stalls", 128'(st), 128'd0);
    chk("wmiss_merge_rdata", 128'(rd_v), 128'h1234_5678);

    mem_log.delete();
    access(1'b1, 1'b0, 30'h2, 32'h0, st, rd_v);
    chk("evict_stalls", 128'(st), 128'(2 + 2 * MEM_LAT));
    chk("evict_rdata", 128'(rd_v), 128'h0000_3333);
    chk("evict_nreq", 128'(mem_log.size()), 128'd2);
    if (mem_log.size() >= 2) begin
      chk("evict_wb_addr", 128'(mem_log[0].addr), 128'h10);
      chk("evict_wb_word2", 128'(mem_log[0].wdata[95:64]), 128'h1234_5678);
      chk("evict_alloc_addr", 128'(mem_log[1].addr), 128'h0);
    end
    idle();

    // Reset in the middle of an allocate aborts the request.
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h100;
    k = 0;
    while (!mem_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("abort_mem_read_up", 128'(mem_read), 128'd1);
    proc_reset = 1'b1;
    #1;
    chk("abort_mem_read_drop", 128'(mem_read), 128'd0);
    chk("abort_mem_addr", 128'(mem_addr), 128'd0);
    proc_read = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;

    mem_log.delete();
    access(1'b1, 1'b0, 30'h2, 32'h0, st, rd_v);
    chk("post_rst_miss_stalls", 128'(st), 128'(1 + MEM_LAT));
    chk("post_rst_rdata", 128'(rd_v), 128'h0000_3333);
    chk("post_rst_nreq", 128'(mem_log.size()), 128'd1);

    // Read and write together on a hit behave as a read only.
    mem_log.delete();
    access(1'b1, 1'b1, 30'h2, 32'hFFFF_FFFF, st, rd_v);
    chk("rw_stalls", 128'(st), 128'd0);
    chk("rw_rdata", 128'(rd_v), 128'h0000_3333);
    access(1'b1, 1'b0, 30'h2, 32'h0, st, rd_v);
    chk("rw_line_unchanged", 128'(rd_v), 128'h0000_3333);
    access(1'b1, 1'b0, 30'h22, 32'h0, st, rd_v);
    chk("rw_clean_evict_stalls", 128'(st), 128'(1 + MEM_LAT));
    chk("rw_clean_evict_nreq", 128'(mem_log.size()), 128'd1);
    chk("rw_clean_evict_rdata", 128'(rd_v), 128'h0008_3333);
    idle();
    repeat (3) @(negedge clk);

    chk("mem_req_stability", 128'(stab_err), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
